// File: rtl/sr_pkg.sv
// Shared types and constants for the set/reset pulse driver.
package sr_pkg;
  localparam int CNT_W = 8;

  localparam logic LVL_SET = 1'b1;
  localparam logic LVL_RST = 1'b0;

  typedef logic [1:0] state_t;

  localparam state_t ST_INIT  = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_PULSE = 2'd2;
  localparam state_t ST_GUARD = 2'd3;
endpackage

// File: rtl/sr_pulse_driver_if.sv
// Command handshake plus latch drive/status between control logic and the driver.
interface sr_pulse_driver_if;
  logic cmd_valid;
  logic cmd_level;
  logic cmd_ready;
  logic s;
  logic r;
  logic state_q;
  logic busy;
  logic done;

  modport master (
    output cmd_valid, cmd_level,
    input  cmd_ready, s, r, state_q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_level,
    output cmd_ready, s, r, state_q, busy, done
  );
endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with zero flag; timed both the pulse and the guard gap.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/sr_pulse_driver.sv
// Turns a level command into a timed set or reset pulse plus guard gap,
// tracking the level the latch is believed to hold.
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_CYC    = 4,
  parameter int unsigned GUARD_CYC    = 2,
  parameter bit          INIT_LEVEL   = 1'b0,
  parameter bit          ALWAYS_PULSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_pulse_driver_if.slave bus
);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = (GUARD_CYC == 0) ? '0 : CNT_W'(GUARD_CYC - 1);

  state_t           state;
  logic             s_q, r_q, done_q, level_q, pulse_lvl;
  logic             accept, go, zero, load;
  logic [CNT_W-1:0] load_val;

  assign accept = bus.cmd_valid && (state == ST_IDLE);
  assign go     = (bus.cmd_level != level_q) || ALWAYS_PULSE;

  always_comb begin
    load     = 1'b0;
    load_val = PULSE_LD;
    case (state)
      ST_INIT:  load = 1'b1;
      ST_IDLE:  load = accept && go;
      ST_PULSE: if (zero && GUARD_CYC != 0) begin
                  load     = 1'b1;
                  load_val = GUARD_LD;
                end
      default:  ;
    endcase
  end

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // s and r are always driven from one level and its complement, so they
  // can never be high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      done_q    <= 1'b0;
      level_q   <= INIT_LEVEL;
      pulse_lvl <= INIT_LEVEL;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_INIT: begin
          state     <= ST_PULSE;
          pulse_lvl <= INIT_LEVEL;
          s_q       <= (INIT_LEVEL == LVL_SET);
          r_q       <= (INIT_LEVEL == LVL_RST);
        end
        ST_IDLE: if (accept) begin
          if (go) begin
            state     <= ST_PULSE;
            pulse_lvl <= bus.cmd_level;
            s_q       <= (bus.cmd_level == LVL_SET);
            r_q       <= (bus.cmd_level == LVL_RST);
          end else begin
            done_q <= 1'b1;
          end
        end
        ST_PULSE: if (zero) begin
          s_q     <= 1'b0;
          r_q     <= 1'b0;
          level_q <= pulse_lvl;
          if (GUARD_CYC == 0) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            state <= ST_GUARD;
          end
        end
        default: if (zero) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.state_q   = level_q;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
endmodule
